// File: rtl/hash_nonce_ctrl_if.sv
// Bundle between the host/probe side, the nonce controller and the 16-byte hash core.
// The controller takes the slave view; the host plus core side takes the master view.
interface hash_nonce_ctrl_if;
  logic         start;
  logic         abort;
  logic [111:0] header;
  logic [7:0]   target;
  logic [7:0]   hash_array0;
  logic [7:0]   hash_array1;
  logic [7:0]   hash_array2;
  logic [7:0]   array_numbers0;
  logic [7:0]   array_numbers1;
  logic [7:0]   array_numbers2;
  logic [7:0]   array_numbers3;
  logic [7:0]   array_numbers4;
  logic [7:0]   array_numbers5;
  logic [7:0]   array_numbers6;
  logic [7:0]   array_numbers7;
  logic [7:0]   array_numbers8;
  logic [7:0]   array_numbers9;
  logic [7:0]   array_numbers10;
  logic [7:0]   array_numbers11;
  logic [7:0]   array_numbers12;
  logic [7:0]   array_numbers13;
  logic [7:0]   array_numbers14;
  logic [7:0]   array_numbers15;
  logic         ready;
  logic         busy;
  logic         done;
  logic         found;
  logic [15:0]  nonce_out;
  logic [23:0]  hash_out;

  modport master (
    output start, abort, header, target, hash_array0, hash_array1, hash_array2,
    input  array_numbers0, array_numbers1, array_numbers2, array_numbers3,
    input  array_numbers4, array_numbers5, array_numbers6, array_numbers7,
    input  array_numbers8, array_numbers9, array_numbers10, array_numbers11,
    input  array_numbers12, array_numbers13, array_numbers14, array_numbers15,
    input  ready, busy, done, found, nonce_out, hash_out
  );

  modport slave (
    input  start, abort, header, target, hash_array0, hash_array1, hash_array2,
    output array_numbers0, array_numbers1, array_numbers2, array_numbers3,
    output array_numbers4, array_numbers5, array_numbers6, array_numbers7,
    output array_numbers8, array_numbers9, array_numbers10, array_numbers11,
    output array_numbers12, array_numbers13, array_numbers14, array_numbers15,
    output ready, busy, done, found, nonce_out, hash_out
  );
endinterface

// File: rtl/hash_nonce_ctrl.sv
// Nonce search sequencer: feeds header+nonce to the hash core, holds ready for the core's
// evaluation window, and stops at the first hash below target or at MAX_NONCE.
module hash_nonce_ctrl #(
  parameter int unsigned CORE_LAT  = 32,
  parameter logic [15:0] MAX_NONCE = 16'hFFFF
) (
  input logic             clk,
  input logic             reset,
  hash_nonce_ctrl_if.slave bus
);

  localparam int unsigned CntW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CORE_LAT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StCheck, StDone} state_e;

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]   nonce_q, nonce_d;
  logic [7:0]    target_q, target_d;
  // Byte k of the core input lives at data[8k+7:8k]; bytes 14/15 carry the nonce.
  logic [127:0]  data_q, data_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
  logic [15:0]   nonce_out_q, nonce_out_d;
  logic [23:0]   hash_out_q, hash_out_d;
  logic [23:0]   sample;
  logic [15:0]   nonce_inc;

  assign sample    = {bus.hash_array0, bus.hash_array1, bus.hash_array2};
  assign nonce_inc = nonce_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nonce_d     = nonce_q;
    target_d    = target_q;
    data_d      = data_q;
    found_d     = found_q;
    nonce_out_d = nonce_out_q;
    hash_out_d  = hash_out_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d     = StLoad;
          target_d    = bus.target;
          nonce_d     = 16'd0;
          data_d      = {16'h0000, bus.header};
          found_d     = 1'b0;
          nonce_out_d = 16'd0;
          hash_out_d  = 24'd0;
        end
      end
      StLoad: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StCheck;
      end
      StCheck: begin
        if (bus.hash_array0 < target_q) begin
          state_d     = StDone;
          found_d     = 1'b1;
          nonce_out_d = nonce_q;
          hash_out_d  = sample;
        end else if (nonce_q == MAX_NONCE) begin
          state_d     = StDone;
          found_d     = 1'b0;
          nonce_out_d = MAX_NONCE;
          hash_out_d  = sample;
        end else begin
          state_d = StLoad;
          nonce_d = nonce_inc;
          data_d  = {nonce_inc[7:0], nonce_inc[15:8], data_q[111:0]};
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort freezes the core inputs where they are but drops every result.
    if (bus.abort) begin
      state_d     = StIdle;
      nonce_d     = nonce_q;
      data_d      = data_q;
      found_d     = 1'b0;
      nonce_out_d = 16'd0;
      hash_out_d  = 24'd0;
    end

    ready_d = (state_d == StRun) || (state_d == StCheck);
    busy_d  = (state_d == StLoad) || (state_d == StRun) || (state_d == StCheck);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      nonce_q     <= 16'd0;
      target_q    <= 8'd0;
      data_q      <= 128'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      nonce_out_q <= 16'd0;
      hash_out_q  <= 24'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nonce_q     <= nonce_d;
      target_q    <= target_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      nonce_out_q <= nonce_out_d;
      hash_out_q  <= hash_out_d;
    end
  end

  assign bus.array_numbers0  = data_q[7:0];
  assign bus.array_numbers1  = data_q[15:8];
  assign bus.array_numbers2  = data_q[23:16];
  assign bus.array_numbers3  = data_q[31:24];
  assign bus.array_numbers4  = data_q[39:32];
  assign bus.array_numbers5  = data_q[47:40];
  assign bus.array_numbers6  = data_q[55:48];
  assign bus.array_numbers7  = data_q[63:56];
  assign bus.array_numbers8  = data_q[71:64];
  assign bus.array_numbers9  = data_q[79:72];
  assign bus.array_numbers10 = data_q[87:80];
  assign bus.array_numbers11 = data_q[95:88];
  assign bus.array_numbers12 = data_q[103:96];
  assign bus.array_numbers13 = data_q[111:104];
  assign bus.array_numbers14 = data_q[119:112];
  assign bus.array_numbers15 = data_q[127:120];

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.nonce_out = nonce_out_q;
  assign bus.hash_out  = hash_out_q;

endmodule

// File: tb/tb_hash_nonce_ctrl.sv
// Bench for hash_nonce_ctrl: a toy hash core, a cycle-count model of the search and
// directed scenarios with hand-computed timing and result expectations.
module tb_hash_nonce_ctrl;
  localparam int unsigned L    = 4;
  localparam logic [15:0] MAXN = 16'd3;
  localparam int          P    = L + 2;

  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   core_mode = 0;
  logic [7:0] hit_at = 8'd2;

  always #5 clk = ~clk;

  hash_nonce_ctrl_if bus ();

  hash_nonce_ctrl #(
    .CORE_LAT (L),
    .MAX_NONCE(MAXN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Toy core: mode 0 hits only when byte15 equals hit_at, mode 1 returns target-equal 8'h10.
  function automatic logic [23:0] core_fn(input logic [111:0] hdr, input logic [15:0] n,
                                          input int mode, input logic [7:0] hit);
    logic [7:0] h0;
    if (mode == 1) h0 = 8'h10;
    else h0 = (n[7:0] == hit) ? 8'h05 : 8'hF0;
    return {h0, n[15:8] ^ hdr[7:0], n[7:0] + hdr[111:104]};
  endfunction

  logic [127:0] dut_arr;
  logic [23:0]  core_out;
  always_comb begin
    dut_arr = {bus.array_numbers15, bus.array_numbers14, bus.array_numbers13,
               bus.array_numbers12, bus.array_numbers11, bus.array_numbers10,
               bus.array_numbers9, bus.array_numbers8, bus.array_numbers7,
               bus.array_numbers6, bus.array_numbers5, bus.array_numbers4,
               bus.array_numbers3, bus.array_numbers2, bus.array_numbers1,
               bus.array_numbers0};
    core_out = core_fn(dut_arr[111:0], {dut_arr[119:112], dut_arr[127:120]}, core_mode, hit_at);
    bus.hash_array0 = core_out[23:16];
    bus.hash_array1 = core_out[15:8];
    bus.hash_array2 = core_out[7:0];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 searching, 2 done. m_e counts edges since the accepted start.
  int          m_st = 0;
  int          m_e = 0;
  logic [111:0] m_hdr = '0;
  logic [15:0] m_nonce = '0, m_fin = '0, m_nout = '0;
  logic [7:0]  m_tgt = '0;
  logic        m_hit = 1'b0, m_found = 1'b0;
  logic [23:0] m_hash = '0;

  always @(posedge clk) begin
    logic [23:0] h;
    if (reset) begin
      m_st = 0; m_e = 0; m_hdr = '0; m_nonce = '0;
      m_found = 1'b0; m_nout = '0; m_hash = '0;
    end else if (bus.abort) begin
      m_st = 0; m_found = 1'b0; m_nout = '0; m_hash = '0;
    end else if (bus.start && m_st != 1) begin
      m_st = 1; m_e = 0; m_hdr = bus.header; m_tgt = bus.target; m_nonce = '0;
      m_found = 1'b0; m_nout = '0; m_hash = '0;
      m_fin = MAXN; m_hit = 1'b0;
      for (int n = 0; n <= int'(MAXN); n++) begin
        h = core_fn(m_hdr, 16'(n), core_mode, hit_at);
        if (h[23:16] < m_tgt) begin
          m_fin = 16'(n); m_hit = 1'b1;
          break;
        end
      end
    end else if (m_st == 1) begin
      m_e++;
      if (m_e >= (int'(m_fin) + 1) * P) begin
        m_st = 2;
        m_found = m_hit;
        m_nout = m_hit ? m_fin : MAXN;
        m_hash = core_fn(m_hdr, m_fin, core_mode, hit_at);
      end else begin
        m_nonce = 16'(m_e / P);
      end
    end
  end

  always @(negedge clk) begin
    logic exp_ready;
    if (chk_en) begin
      exp_ready = (m_st == 1) && ((m_e % P) != 0);
      check("ctrl", {84'd0, bus.ready, bus.busy, bus.done, bus.found, bus.nonce_out,
                     bus.hash_out},
            {84'd0, exp_ready, m_st == 1, m_st == 2, m_found, m_nout, m_hash});
      check("core_bytes", dut_arr, {m_nonce[7:0], m_nonce[15:8], m_hdr});
    end
  end

  // Pulses start for one cycle; returns in cycle 1 (LOAD) relative to the start cycle.
  task automatic do_start(input logic [111:0] hdr, input logic [7:0] tgt);
    @(negedge clk);
    bus.header = hdr;
    bus.target = tgt;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc, output int lows, output int maxb,
                           output logic [23:0] seq);
    cyc = c0; lows = 0; maxb = 0; seq = '0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy && !bus.ready) begin
        lows++;
        seq = {seq[15:0], bus.array_numbers15};
      end
      if (bus.busy && int'(bus.array_numbers15) > maxb) maxb = int'(bus.array_numbers15);
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, cyc);
    end
  endtask

  localparam logic [111:0] HdrA = 112'h0D0C0B0A09080706050403020100;
  localparam logic [111:0] HdrB = {14{8'hAA}};

  initial begin
    int cyc, lows, maxb;
    logic [23:0] seq;
    bus.start = 1'b0; bus.abort = 1'b0; bus.header = '0; bus.target = '0;
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_state", {bus.ready, bus.busy, bus.done, bus.found, bus.nonce_out,
                          bus.hash_out, dut_arr}, '0);

    // Reset for 3 cycles mid-RUN, with start held during reset.
    do_start(HdrA, 8'h10);
    repeat (2) @(negedge clk);
    reset = 1'b1; bus.start = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    check("reset_mid_run", {bus.ready, bus.busy, bus.done, bus.found, bus.nonce_out,
                            bus.hash_out, dut_arr}, '0);
    @(negedge clk);
    check("start_in_reset_ignored", {127'd0, bus.busy}, '0);

    // Hit at nonce 2.
    do_start(HdrA, 8'h10);
    wait_done(1, cyc, lows, maxb, seq);
    check("hit_done_cycle", 128'(cyc), 128'd19);
    check("hit_found", {127'd0, bus.found}, 128'd1);
    check("hit_nonce", {112'd0, bus.nonce_out}, 128'd2);
    check("hit_hash0", {120'd0, bus.hash_out[23:16]}, 128'h05);
    check("hit_ready_gaps", 128'(lows), 128'd3);
    check("hit_nonce_seq", {104'd0, seq}, 128'h000102);

    // Restart from DONE with a new header; a start pulse mid-RUN is ignored.
    do_start(HdrB, 8'h10);
    check("restart_done_drop", {127'd0, bus.done}, '0);
    check("restart_bytes", dut_arr, {16'h0000, HdrB});
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.header = '0; bus.target = '0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(4, cyc, lows, maxb, seq);
    check("restart_done_cycle", 128'(cyc), 128'd19);
    check("restart_nonce", {111'd0, bus.found, bus.nonce_out}, {111'd0, 1'b1, 16'd2});

    // Exhaustion with target 0.
    do_start(HdrA, 8'h00);
    wait_done(1, cyc, lows, maxb, seq);
    check("exh_done_cycle", 128'(cyc), 128'd25);
    check("exh_result", {111'd0, bus.found, bus.nonce_out}, {111'd0, 1'b0, 16'd3});
    check("exh_max_nonce_seen", 128'(maxb), 128'd3);

    // Strict compare: hash equal to target never hits.
    core_mode = 1;
    do_start(HdrA, 8'h10);
    wait_done(1, cyc, lows, maxb, seq);
    check("strict_done_cycle", 128'(cyc), 128'd25);
    check("strict_result", {111'd0, bus.found, bus.nonce_out}, {111'd0, 1'b0, 16'd3});
    check("strict_hash0", {120'd0, bus.hash_out[23:16]}, 128'h10);
    core_mode = 0;

    // Abort during cycle 3, then a fresh start from nonce 0.
    do_start(HdrA, 8'h10);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_idle", {125'd0, bus.ready, bus.busy, bus.done}, '0);
    check("abort_bytes_kept", dut_arr, {16'h0000, HdrA});
    do_start(HdrA, 8'h10);
    check("abort_restart_load", {119'd0, bus.busy, bus.array_numbers15}, {119'd0, 1'b1, 8'd0});
    wait_done(1, cyc, lows, maxb, seq);
    check("abort_restart_done", 128'(cyc), 128'd19);
    @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
